// File: rtl/rect_fill_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | rect_fill_engine                                                         |
// | Rasterises one clipped, filled rectangle into the vga_core write port.   |
// | Optional feature macro: RECT_FILL_CLEAR_EN (adds full-canvas clear).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rect_fill_engine #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] rx0,
  input  logic [6:0] ry0,
  input  logic [7:0] rw,
  input  logic [6:0] rh,
  input  logic [2:0] rcolor,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] color,
  output logic       plot,
  output logic       busy,
  output logic       done
`ifdef RECT_FILL_CLEAR_EN
  ,
  input  logic       clear
`endif
);

  localparam logic [8:0] c_w9     = 9'(SCREEN_W);
  localparam logic [7:0] c_h8     = 8'(SCREEN_H);
  localparam logic [8:0] c_x_max  = 9'(SCREEN_W - 1);
  localparam logic [7:0] c_y_max  = 8'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLIP = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] rx0_q, rx0_d;
  logic [6:0] ry0_q, ry0_d;
  logic [7:0] rw_q, rw_d;
  logic [6:0] rh_q, rh_d;
  logic [2:0] rcolor_q, rcolor_d;
  logic [7:0] x_last_q, x_last_d;
  logic [6:0] y_last_q, y_last_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] color_q, color_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [8:0] w_x_end;
  logic [7:0] w_y_end;
  logic       w_empty;

  // Widened sums so a rectangle running past the canvas edge cannot wrap.
  assign w_x_end = {1'b0, rx0_q} + {1'b0, rw_q} - 9'd1;
  assign w_y_end = {1'b0, ry0_q} + {1'b0, rh_q} - 8'd1;
  assign w_empty = (rw_q == 8'd0) || (rh_q == 7'd0) ||
                   ({1'b0, rx0_q} >= c_w9) || ({1'b0, ry0_q} >= c_h8);

  always_comb begin
    state_d  = state_q;
    rx0_d    = rx0_q;
    ry0_d    = ry0_q;
    rw_d     = rw_q;
    rh_d     = rh_q;
    rcolor_d = rcolor_q;
    x_last_d = x_last_q;
    y_last_d = y_last_q;
    x_d      = x_q;
    y_d      = y_q;
    color_d  = color_q;
    plot_d   = plot_q;
    busy_d   = busy_q;
    done_d   = done_q;

    case (state_q)
      S_IDLE: begin
        plot_d = 1'b0;
        done_d = 1'b0;
`ifdef RECT_FILL_CLEAR_EN
        // A clear is just a canvas-sized rectangle in colour 0.
        if (clear) begin
          rx0_d    = 8'd0;
          ry0_d    = 7'd0;
          rw_d     = c_w9[7:0];
          rh_d     = c_h8[6:0];
          rcolor_d = 3'd0;
          busy_d   = 1'b1;
          state_d  = S_CLIP;
        end else
`endif
        if (start) begin
          rx0_d    = rx0;
          ry0_d    = ry0;
          rw_d     = rw;
          rh_d     = rh;
          rcolor_d = rcolor;
          busy_d   = 1'b1;
          state_d  = S_CLIP;
        end
      end

      S_CLIP: begin
        x_last_d = (w_x_end > c_x_max) ? c_x_max[7:0] : w_x_end[7:0];
        y_last_d = (w_y_end > c_y_max) ? c_y_max[6:0] : w_y_end[6:0];
        if (w_empty) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          x_d     = rx0_q;
          y_d     = ry0_q;
          color_d = rcolor_q;
          plot_d  = 1'b1;
          state_d = S_DRAW;
        end
      end

      S_DRAW: begin
        if (x_q == x_last_q) begin
          if (y_q == y_last_q) begin
            plot_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            x_d = rx0_q;
            y_d = y_q + 7'd1;
          end
        end else begin
          x_d = x_q + 8'd1;
        end
      end

      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        plot_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        plot_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      rx0_q    <= 8'd0;
      ry0_q    <= 7'd0;
      rw_q     <= 8'd0;
      rh_q     <= 7'd0;
      rcolor_q <= 3'd0;
      x_last_q <= 8'd0;
      y_last_q <= 7'd0;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      color_q  <= 3'd0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx0_q    <= rx0_d;
      ry0_q    <= ry0_d;
      rw_q     <= rw_d;
      rh_q     <= rh_d;
      rcolor_q <= rcolor_d;
      x_last_q <= x_last_d;
      y_last_q <= y_last_d;
      x_q      <= x_d;
      y_q      <= y_d;
      color_q  <= color_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign color = color_q;
  assign plot  = plot_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rect_fill_engine.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for rect_fill_engine: pixel scoreboard filled from an independent
// rectangle/clipping model, drained by a plot monitor on the falling edge.
module tb_rect_fill_engine;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [7:0] rx0, rw;
  logic [6:0] ry0, rh;
  logic [2:0] rcolor;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;
  logic       plot, busy, done;
`ifdef RECT_FILL_CLEAR_EN
  logic       clear;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  rect_fill_engine dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .rx0    (rx0),
    .ry0    (ry0),
    .rw     (rw),
    .rh     (rh),
    .rcolor (rcolor),
    .x      (x),
    .y      (y),
    .color  (color),
    .plot   (plot),
    .busy   (busy),
    .done   (done)
`ifdef RECT_FILL_CLEAR_EN
    ,
    .clear  (clear)
`endif
  );

  // Every plotted pixel must be the next one the model expects.
  always @(negedge clk) begin
    logic [17:0] e;
    if (resetn === 1'b1 && plot === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_plot got x=%0d y=%0d color=%0d, expected no plot", x, y, color);
      end else begin
        e = exp_q.pop_front();
        if ({x, y, color} !== e) begin
          tests_failed++;
          $display("FAIL pixel got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                   x, y, color, e[17:10], e[9:3], e[2:0]);
        end
      end
    end
  end

  function automatic void push_rect(input int x0, input int y0, input int w, input int h, input int col);
    for (int yy = y0; yy < y0 + h; yy++)
      if (yy < 120)
        for (int xx = x0; xx < x0 + w; xx++)
          if (xx < 160) exp_q.push_back({8'(xx), 7'(yy), 3'(col)});
  endfunction

  // Leaves the caller on the falling edge right after the sampling edge;
  // operands are scrambled afterwards so only latched values can be used.
  task automatic pulse_start(input int x0, input int y0, input int w, input int h, input int col);
    @(negedge clk);
    rx0 = 8'(x0); ry0 = 7'(y0); rw = 8'(w); rh = 7'(h); rcolor = 3'(col);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rx0 = ~rx0; ry0 = ~ry0; rw = ~rw; rh = ~rh; rcolor = ~rcolor;
  endtask

  task automatic wait_done(input int budget, output int k, output bit ok);
    k = 0; ok = 1'b0;
    while (k < budget && !ok) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; rx0 = 0; ry0 = 0; rw = 0; rh = 0; rcolor = 0;
`ifdef RECT_FILL_CLEAR_EN
    clear = 1'b0;
`endif
    #12;
    tests_run++;
    if ({x, y, color, plot, busy, done} !== 21'd0) begin
      tests_failed++;
      $display("FAIL reset_state got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b expected all 0",
               x, y, color, plot, busy, done);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_rect(input string name, input int x0, input int y0, input int w, input int h, input int col);
    int n, k; bit ok;
    n = exp_q.size();
    push_rect(x0, y0, w, h, col);
    n = exp_q.size() - n;
    pulse_start(x0, y0, w, h, col);
    tests_run++;
    if (busy !== 1'b1 || plot !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_accept got busy=%b plot=%b expected busy=1 plot=0", name, busy, plot);
    end
    wait_done(n + 40, k, ok);
    tests_run++;
    if (!ok || k != ((n == 0) ? 1 : n + 1)) begin
      tests_failed++;
      $display("FAIL %s_done_cycle got k=%0d seen=%0d expected k=%0d", name, k, ok, (n == 0) ? 1 : n + 1);
    end
    tests_run++;
    if (exp_q.size() != 0 || plot !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_pixel_count got %0d left plot=%b expected 0 left plot=0", name, exp_q.size(), plot);
    end
    exp_q.delete();
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_idle got done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_basic();
    int k; bit ok;
    push_rect(10, 20, 3, 2, 5);
    pulse_start(10, 20, 3, 2, 5);
    @(negedge clk);
    tests_run++;
    if (plot !== 1'b1 || x !== 8'd10 || y !== 7'd20 || color !== 3'd5) begin
      tests_failed++;
      $display("FAIL basic_first_plot got plot=%b (%0d,%0d,c%0d) expected plot=1 (10,20,c5)", plot, x, y, color);
    end
    wait_done(40, k, ok);
    tests_run++;
    if (!ok || k != 6) begin
      tests_failed++;
      $display("FAIL basic_done_cycle got k=%0d seen=%0d expected k=6", k, ok);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL basic_pixel_count got %0d left expected 0", exp_q.size());
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_clip_and_empty();
    run_rect("corner", 158, 118, 5, 5, 2);
    run_rect("empty_w0", 10, 10, 0, 4, 1);
    run_rect("empty_x200", 200, 10, 4, 4, 1);
    run_rect("empty_h0", 3, 3, 5, 0, 7);
    run_rect("empty_y125", 3, 125, 5, 2, 7);
    run_rect("edge_x", 150, 5, 200, 1, 4);
  endtask

  task automatic test_restart_ignored();
    int k; bit ok;
    push_rect(30, 40, 4, 3, 6);
    pulse_start(30, 40, 4, 3, 6);
    repeat (3) @(negedge clk);
    pulse_start(0, 0, 8, 8, 1);
    wait_done(60, k, ok);
    tests_run++;
    if (!ok || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL restart_done got seen=%0d left=%0d expected seen=1 left=0", ok, exp_q.size());
    end
    exp_q.delete();
    ok = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) ok = 1'b1;
    end
    tests_run++;
    if (ok) begin
      tests_failed++;
      $display("FAIL restart_not_queued got activity after done expected idle");
    end
  endtask

  task automatic test_back_to_back();
    run_rect("b2b_a", 0, 0, 2, 2, 3);
    run_rect("b2b_b", 5, 6, 3, 1, 1);
    for (int i = 0; i < 4; i++)
      run_rect("random", $urandom_range(130, 170), $urandom_range(100, 127),
               $urandom_range(0, 15), $urandom_range(0, 8), $urandom_range(0, 7));
  endtask

  task automatic test_reset_mid_draw();
    bit bad;
    push_rect(5, 5, 20, 10, 3);
    pulse_start(5, 5, 20, 10, 3);
    repeat (4) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    tests_run++;
    if ({x, y, color, plot, busy, done} !== 21'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_draw got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b expected all 0",
               x, y, color, plot, busy, done);
    end
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (plot !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL reset_resume got plot/done after reset expected none");
    end
  endtask

`ifdef RECT_FILL_CLEAR_EN
  task automatic test_clear();
    int k; bit ok;
    push_rect(0, 0, 160, 120, 0);
    @(negedge clk);
    rx0 = 8'd7; ry0 = 7'd7; rw = 8'd2; rh = 7'd2; rcolor = 3'd6;
    clear = 1'b1; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    wait_done(19300, k, ok);
    tests_run++;
    if (!ok || k != 19201 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL clear got k=%0d seen=%0d left=%0d expected k=19201 seen=1 left=0", k, ok, exp_q.size());
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_clip_and_empty();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid_draw();
    run_rect("after_reset", 1, 2, 2, 2, 5);
`ifdef RECT_FILL_CLEAR_EN
    test_clear();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
